// File: rtl/nvme_pcie_pkg.sv
// Shared definitions for the PCIe completer-request (CQ) receive path.
// Holds the CQ request-type codes, the rx_cq FSM encoding, the BAR0 id,
// the 128-bit descriptor bit positions, the queued request record and a
// dword-count to byte-count helper.
package nvme_pcie_pkg;

   localparam logic [3:0] CQ_TYPE_MEM_RD = 4'b0000;
   localparam logic [3:0] CQ_TYPE_MEM_WR = 4'b0001;

   localparam logic [2:0] CQ_BAR0 = 3'd0;

   localparam int CQ_ADDR_LSB   = 2;
   localparam int CQ_ADDR_MSB   = 6;
   localparam int CQ_DW_CNT_LSB = 64;
   localparam int CQ_TYPE_LSB   = 75;
   localparam int CQ_REQ_ID_LSB = 80;
   localparam int CQ_TAG_LSB    = 96;
   localparam int CQ_BAR_LSB    = 112;
   localparam int CQ_TC_LSB     = 121;
   localparam int CQ_ATTR_LSB   = 124;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DROP = 1'b1
   } cq_state_e;

   typedef struct packed {
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic [6:0]  addr;
      logic [10:0] dw_cnt;
      logic [12:0] byte_cnt;
      logic [2:0]  tc;
      logic [2:0]  attr;
   } cq_req_t;

   // A dword count of zero encodes the maximum length of 1024 dwords.
   function automatic logic [12:0] cq_byte_cnt(input logic [10:0] dw_cnt);
      return (dw_cnt == 11'd0) ? 13'h1000 : {dw_cnt, 2'b00};
   endfunction

endpackage

// File: rtl/rx_cq_if.sv
// Completer-request stream plus the read-command handshake towards the
// request consumer.
//   master : drives the CQ beat (tdata/tuser/tlast/tkeep/tvalid) and
//            send_cmd_done; receives tready and the head request.
//   slave  : rx_cq side of the same signals.
interface rx_cq_if #(
   parameter int DATA_W  = 128,
   parameter int TUSER_W = 88,
   parameter int KEEP_W  = DATA_W / 32
);
   logic [DATA_W-1:0]  m_axis_cq_tdata;
   logic [TUSER_W-1:0] m_axis_cq_tuser;
   logic               m_axis_cq_tlast;
   logic [KEEP_W-1:0]  m_axis_cq_tkeep;
   logic               m_axis_cq_tvalid;
   logic [21:0]        m_axis_cq_tready;

   logic               send_cmd;
   logic               send_cmd_done;
   logic [15:0]        req_requester_id;
   logic [7:0]         req_tag;
   logic [6:0]         req_addr;
   logic [10:0]        req_dw_cnt;
   logic [12:0]        req_byte_cnt;
   logic [2:0]         req_tc;
   logic [2:0]         req_attr;

   modport master (
      output m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast,
             m_axis_cq_tkeep, m_axis_cq_tvalid, send_cmd_done,
      input  m_axis_cq_tready, send_cmd, req_requester_id, req_tag,
             req_addr, req_dw_cnt, req_byte_cnt, req_tc, req_attr
   );

   modport slave (
      input  m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast,
             m_axis_cq_tkeep, m_axis_cq_tvalid, send_cmd_done,
      output m_axis_cq_tready, send_cmd, req_requester_id, req_tag,
             req_addr, req_dw_cnt, req_byte_cnt, req_tc, req_attr
   );
endinterface

// File: rtl/cq_req_fifo.sv
// Small FIFO for queued read requests with a registered head output.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        synchronous clear of pointers, occupancy and head
//   push/wr_data write one entry (ignored when full)
//   pop          retire head entry (ignored when empty)
//   rd_data      registered head entry, zero when empty
//   full, empty  occupancy flags
module cq_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             push_ok, pop_ok;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign push_ok    = push & ~full;
   assign pop_ok     = pop & ~empty;
   assign rd_ptr_nxt = rd_ptr_q + PW'(1);
   assign rd_data    = dout_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_nxt;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // The head register must already hold the next entry when the
      // pointer moves, so look one slot ahead or bypass the write data.
      if (pop_ok) begin
         if (count_q > CW'(1)) dout_d = mem_q[rd_ptr_nxt];
         else if (push_ok)     dout_d = wr_data;
         else                  dout_d = '0;
      end else if (push_ok && empty) begin
         dout_d = wr_data;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         dout_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/rx_cq.sv
// Completer-request receive front end. Parses single-beat CQ descriptors,
// queues memory reads for the command engine, drops write payloads and
// unsupported requests, and keeps request statistics.
// Ports:
//   user_clk, user_reset_n  clock, async active-low reset
//   user_lnk_up             low flushes queue, FSM and counters
//   cq                      CQ stream in, head read request out
//   rd/wr/bad_req_cnt       wrapping request counters
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | next accepted beat is a descriptor
//   ST_DROP | discarding payload beats until tlast
module rx_cq
   import nvme_pcie_pkg::*;
#(
   parameter int C_DATA_WIDTH        = 128,
   parameter int AXI4_CQ_TUSER_WIDTH = 88,
   parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic        user_clk,
   input  logic        user_reset_n,
   input  logic        user_lnk_up,
   rx_cq_if.slave      cq,
   output logic [15:0] rd_req_cnt,
   output logic [15:0] wr_req_cnt,
   output logic [15:0] bad_req_cnt
);
   cq_state_e                      state_q, state_d;
   logic [C_DATA_WIDTH-1:0]        tdata;
   logic [AXI4_CQ_TUSER_WIDTH-1:0] tuser_unused;
   logic [KEEP_WIDTH-1:0]          tkeep_unused;
   logic                           unused_sigs;
   logic                           rdy_en_q, rdy_en_d;
   logic                           ready, beat_ok, push, pop;
   logic [3:0]                     req_type;
   logic [15:0]                    rd_cnt_q, rd_cnt_d;
   logic [15:0]                    wr_cnt_q, wr_cnt_d;
   logic [15:0]                    bad_cnt_q, bad_cnt_d;
   logic                           fifo_full, fifo_empty;
   cq_req_t                        desc, head;

   assign tdata        = cq.m_axis_cq_tdata;
   assign tuser_unused = cq.m_axis_cq_tuser;
   assign tkeep_unused = cq.m_axis_cq_tkeep;
   // Only BAR0 maps onto this block, so the BAR id is not decoded.
   assign unused_sigs  = ^{tdata, tdata[CQ_BAR_LSB +: 3] ^ CQ_BAR0};

   assign req_type = tdata[CQ_TYPE_LSB +: 4];

   always_comb begin
      desc              = '0;
      desc.requester_id = tdata[CQ_REQ_ID_LSB +: 16];
      desc.tag          = tdata[CQ_TAG_LSB +: 8];
      desc.addr         = {tdata[CQ_ADDR_MSB:CQ_ADDR_LSB], 2'b00};
      desc.dw_cnt       = tdata[CQ_DW_CNT_LSB +: 11];
      desc.byte_cnt     = cq_byte_cnt(tdata[CQ_DW_CNT_LSB +: 11]);
      desc.tc           = tdata[CQ_TC_LSB +: 3];
      desc.attr         = tdata[CQ_ATTR_LSB +: 3];
   end

   // rdy_en_q holds tready low until the first edge after reset release.
   assign rdy_en_d = 1'b1;
   assign ready    = rdy_en_q & user_lnk_up &
                     ((state_q == ST_DROP) | ~fifo_full);
   assign cq.m_axis_cq_tready = {22{ready}};
   assign beat_ok  = cq.m_axis_cq_tvalid & cq.m_axis_cq_tready[0];
   assign pop      = cq.send_cmd_done & user_lnk_up;

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      bad_cnt_d = bad_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (beat_ok) begin
               case (req_type)
                  CQ_TYPE_MEM_RD: begin
                     push     = 1'b1;
                     rd_cnt_d = rd_cnt_q + 16'd1;
                  end
                  CQ_TYPE_MEM_WR: wr_cnt_d  = wr_cnt_q + 16'd1;
                  default:        bad_cnt_d = bad_cnt_q + 16'd1;
               endcase
               if (!cq.m_axis_cq_tlast) state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (beat_ok && cq.m_axis_cq_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (!user_lnk_up) begin
         state_d   = ST_IDLE;
         push      = 1'b0;
         rd_cnt_d  = '0;
         wr_cnt_d  = '0;
         bad_cnt_d = '0;
      end
   end

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state_q   <= ST_IDLE;
         rdy_en_q  <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         bad_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rdy_en_q  <= rdy_en_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         bad_cnt_q <= bad_cnt_d;
      end
   end

   cq_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cq_req_t))
   ) u_fifo (
      .clk     (user_clk),
      .rst_n   (user_reset_n),
      .flush   (~user_lnk_up),
      .push    (push),
      .wr_data (desc),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign cq.send_cmd         = ~fifo_empty;
   assign cq.req_requester_id = head.requester_id;
   assign cq.req_tag          = head.tag;
   assign cq.req_addr         = head.addr;
   assign cq.req_dw_cnt       = head.dw_cnt;
   assign cq.req_byte_cnt     = head.byte_cnt;
   assign cq.req_tc           = head.tc;
   assign cq.req_attr         = head.attr;

   assign rd_req_cnt  = rd_cnt_q;
   assign wr_req_cnt  = wr_cnt_q;
   assign bad_req_cnt = bad_cnt_q;

endmodule

// File: tb/tb_rx_cq.sv
// Self-checking bench for rx_cq: MemRd descriptors push expected requests
// into a scoreboard queue; each pop compares the DUT head against it.
module tb_rx_cq;
   import nvme_pcie_pkg::*;

   logic        user_clk     = 1'b0;
   logic        user_reset_n = 1'b0;
   logic        user_lnk_up  = 1'b1;
   logic [15:0] rd_req_cnt, wr_req_cnt, bad_req_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] rid;
      logic [7:0]  tag;
      logic [6:0]  addr;
      logic [10:0] dw;
      logic [12:0] bc;
      logic [2:0]  tc;
      logic [2:0]  attr;
   } exp_t;

   exp_t exp_q[$];

   rx_cq_if #(.DATA_W(128), .TUSER_W(88), .KEEP_W(4)) cq_if ();

   rx_cq #(
      .C_DATA_WIDTH        (128),
      .AXI4_CQ_TUSER_WIDTH (88),
      .KEEP_WIDTH          (4),
      .FIFO_DEPTH          (4)
   ) dut (
      .user_clk     (user_clk),
      .user_reset_n (user_reset_n),
      .user_lnk_up  (user_lnk_up),
      .cq           (cq_if),
      .rd_req_cnt   (rd_req_cnt),
      .wr_req_cnt   (wr_req_cnt),
      .bad_req_cnt  (bad_req_cnt)
   );

   always #5 user_clk = ~user_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "time limit");
   end

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_desc(input logic [3:0] typ,
      input logic [15:0] rid, input logic [7:0] tag, input logic [10:0] dw,
      input logic [6:0] addr, input logic [2:0] tc, input logic [2:0] attr);
      logic [127:0] d;
      d           = {32'h5A5A_0000, 32'h0, 32'h1357_9BDF, 32'h0};
      d[1:0]      = 2'b11;
      d[6:2]      = addr[6:2];
      d[74:64]    = dw;
      d[78:75]    = typ;
      d[79]       = 1'b1;
      d[95:80]    = rid;
      d[103:96]   = tag;
      d[123:121]  = tc;
      d[126:124]  = attr;
      return d;
   endfunction

   // Entry point and exit point: just after a falling edge.
   task automatic send_beat(input logic [127:0] d, input logic last);
      int n;
      n = 0;
      cq_if.m_axis_cq_tdata  = d;
      cq_if.m_axis_cq_tlast  = last;
      cq_if.m_axis_cq_tvalid = 1'b1;
      #1;
      while (!cq_if.m_axis_cq_tready[0] && n < 50) begin
         @(negedge user_clk);
         #1;
         n++;
      end
      check_val("tready_wait", 64'(cq_if.m_axis_cq_tready[0]), 64'd1);
      @(negedge user_clk);
      cq_if.m_axis_cq_tvalid = 1'b0;
      cq_if.m_axis_cq_tlast  = 1'b0;
   endtask

   function automatic exp_t mk_exp(input logic [15:0] rid,
      input logic [7:0] tag, input logic [10:0] dw, input logic [6:0] addr,
      input logic [2:0] tc, input logic [2:0] attr);
      exp_t e;
      e.rid  = rid;
      e.tag  = tag;
      e.addr = {addr[6:2], 2'b00};
      e.dw   = dw;
      e.bc   = (dw == 11'd0) ? 13'd4096 : 13'(dw) * 13'd4;
      e.tc   = tc;
      e.attr = attr;
      return e;
   endfunction

   task automatic send_mrd(input logic [7:0] tag, input logic [15:0] rid,
      input logic [10:0] dw, input logic [6:0] addr, input logic [2:0] tc,
      input logic [2:0] attr);
      exp_q.push_back(mk_exp(rid, tag, dw, addr, tc, attr));
      send_beat(mk_desc(4'b0000, rid, tag, dw, addr, tc, attr), 1'b1);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      e = exp_q.pop_front();
      check_val({tag, "_send_cmd"}, 64'(cq_if.send_cmd), 64'd1);
      check_val({tag, "_tag"},  64'(cq_if.req_tag), 64'(e.tag));
      check_val({tag, "_rid"},  64'(cq_if.req_requester_id), 64'(e.rid));
      check_val({tag, "_addr"}, 64'(cq_if.req_addr), 64'(e.addr));
      check_val({tag, "_dw"},   64'(cq_if.req_dw_cnt), 64'(e.dw));
      check_val({tag, "_bc"},   64'(cq_if.req_byte_cnt), 64'(e.bc));
      check_val({tag, "_tc"},   64'(cq_if.req_tc), 64'(e.tc));
      check_val({tag, "_attr"}, 64'(cq_if.req_attr), 64'(e.attr));
      cq_if.send_cmd_done = 1'b1;
      @(negedge user_clk);
      cq_if.send_cmd_done = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check_val({tag, "_tready"},  64'(cq_if.m_axis_cq_tready), 64'd0);
      check_val({tag, "_sendcmd"}, 64'(cq_if.send_cmd), 64'd0);
      check_val({tag, "_state"},   64'(dut.state_q), 64'(ST_IDLE));
      check_val({tag, "_count"},   64'(dut.u_fifo.count_q), 64'd0);
      check_val({tag, "_cnts"},    {16'd0, rd_req_cnt, wr_req_cnt, bad_req_cnt}, 64'd0);
      check_val({tag, "_head"},    {cq_if.req_requester_id, cq_if.req_tag,
                                    cq_if.req_addr, cq_if.req_dw_cnt}, 64'd0);
      check_val({tag, "_bc"},      64'(cq_if.req_byte_cnt), 64'd0);
      check_val({tag, "_tcattr"},  64'({cq_if.req_tc, cq_if.req_attr}), 64'd0);
   endtask

   initial begin
      cq_if.m_axis_cq_tdata  = '0;
      cq_if.m_axis_cq_tuser  = 88'({$urandom, $urandom, $urandom});
      cq_if.m_axis_cq_tkeep  = 4'hF;
      cq_if.m_axis_cq_tlast  = 1'b0;
      cq_if.m_axis_cq_tvalid = 1'b0;
      cq_if.send_cmd_done    = 1'b0;

      // reset
      repeat (3) @(negedge user_clk);
      check_cleared("rst");
      #2 user_reset_n = 1'b1;
      #1 check_val("tready_at_release", 64'(cq_if.m_axis_cq_tready), 64'd0);
      @(negedge user_clk);
      check_val("tready_after_release", 64'(cq_if.m_axis_cq_tready), 64'h3F_FFFF);

      // basic MemRd
      send_mrd(8'h05, 16'h0100, 11'd16, 7'h40, 3'd0, 3'd0);
      check_val("t024_send_cmd", 64'(cq_if.send_cmd), 64'd1);
      check_val("t024_bc", 64'(cq_if.req_byte_cnt), 64'd64);
      check_val("t024_tag", 64'(cq_if.req_tag), 64'h05);
      check_val("t024_rd_cnt", 64'(rd_req_cnt), 64'd1);
      pop_check("t024");
      check_val("t024_empty", 64'(cq_if.send_cmd), 64'd0);

      // dw_cnt 0 => 4096 bytes
      send_mrd(8'h06, 16'hABCD, 11'd0, 7'h7C, 3'd3, 3'd5);
      check_val("t027_bc", 64'(cq_if.req_byte_cnt), 64'd4096);
      pop_check("t027");

      // MemWr with payload that looks like a MemRd descriptor
      send_beat(mk_desc(4'b0001, 16'h0200, 8'h07, 11'd1, 7'h10, 3'd0, 3'd0), 1'b0);
      check_val("t026_state_drop", 64'(dut.state_q), 64'(ST_DROP));
      check_val("t026_wr_cnt", 64'(wr_req_cnt), 64'd1);
      send_beat(mk_desc(4'b0000, 16'h0300, 8'h08, 11'd2, 7'h00, 3'd0, 3'd0), 1'b1);
      check_val("t026_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
      check_val("t026_no_push", 64'(cq_if.send_cmd), 64'd0);
      check_val("t026_rd_cnt", 64'(rd_req_cnt), 64'd2);

      // unsupported types, single and multi beat
      send_beat(mk_desc(4'b0010, 16'h0400, 8'h09, 11'd1, 7'h00, 3'd0, 3'd0), 1'b1);
      check_val("bad1_cnt", 64'(bad_req_cnt), 64'd1);
      check_val("bad1_state", 64'(dut.state_q), 64'(ST_IDLE));
      send_beat(mk_desc(4'b1100, 16'h0500, 8'h0A, 11'd8, 7'h00, 3'd0, 3'd0), 1'b0);
      send_beat(128'h0, 1'b0);
      check_val("bad2_state_mid", 64'(dut.state_q), 64'(ST_DROP));
      send_beat(128'h0, 1'b1);
      check_val("bad2_cnt", 64'(bad_req_cnt), 64'd2);
      check_val("bad2_state", 64'(dut.state_q), 64'(ST_IDLE));
      check_val("bad2_no_push", 64'(cq_if.send_cmd), 64'd0);

      // fill to full, fifth held off until one pop
      for (int i = 0; i < 4; i++)
         send_mrd(8'h10 + 8'(i), 16'h1000 + 16'(i), 11'd4 + 11'(i),
                  7'h20 + 7'(i * 4), 3'(i), 3'(7 - i));
      check_val("t025_full_ready", 64'(cq_if.m_axis_cq_tready), 64'd0);
      check_val("t025_count4", 64'(dut.u_fifo.count_q), 64'd4);
      exp_q.push_back(mk_exp(16'h2000, 8'h14, 11'd9, 7'h44, 3'd1, 3'd2));
      cq_if.m_axis_cq_tdata  = mk_desc(4'b0000, 16'h2000, 8'h14, 11'd9, 7'h44, 3'd1, 3'd2);
      cq_if.m_axis_cq_tlast  = 1'b1;
      cq_if.m_axis_cq_tvalid = 1'b1;
      repeat (2) @(negedge user_clk);
      check_val("t025_hold_ready", 64'(cq_if.m_axis_cq_tready[0]), 64'd0);
      check_val("t025_hold_rd_cnt", 64'(rd_req_cnt), 64'd6);
      check_val("t025_head_stable", 64'(cq_if.req_tag), 64'h10);
      pop_check("t025_0");
      check_val("t025_ready_after_pop", 64'(cq_if.m_axis_cq_tready[0]), 64'd1);
      @(negedge user_clk);
      cq_if.m_axis_cq_tvalid = 1'b0;
      cq_if.m_axis_cq_tlast  = 1'b0;
      check_val("t025_rd_cnt", 64'(rd_req_cnt), 64'd7);
      check_val("t025_count_refill", 64'(dut.u_fifo.count_q), 64'd4);
      for (int i = 1; i < 5; i++) pop_check($sformatf("t025_%0d", i));
      check_val("t025_drained", 64'(cq_if.send_cmd), 64'd0);

      // simultaneous push/pop at occupancy 2, then pop while empty
      send_mrd(8'h20, 16'h3000, 11'd1, 7'h04, 3'd0, 3'd1);
      send_mrd(8'h21, 16'h3001, 11'd2, 7'h08, 3'd1, 3'd0);
      check_val("t028_count2", 64'(dut.u_fifo.count_q), 64'd2);
      exp_q.push_back(mk_exp(16'h3002, 8'h22, 11'd3, 7'h0C, 3'd2, 3'd3));
      cq_if.m_axis_cq_tdata  = mk_desc(4'b0000, 16'h3002, 8'h22, 11'd3, 7'h0C, 3'd2, 3'd3);
      cq_if.m_axis_cq_tlast  = 1'b1;
      cq_if.m_axis_cq_tvalid = 1'b1;
      pop_check("t028_a");
      cq_if.m_axis_cq_tvalid = 1'b0;
      check_val("t028_count_same", 64'(dut.u_fifo.count_q), 64'd2);
      pop_check("t028_b");
      pop_check("t028_c");
      check_val("t028_empty", 64'(cq_if.send_cmd), 64'd0);
      cq_if.send_cmd_done = 1'b1;
      @(negedge user_clk);
      cq_if.send_cmd_done = 1'b0;
      check_val("t028_empty_pop_count", 64'(dut.u_fifo.count_q), 64'd0);
      check_val("t028_empty_pop_cmd", 64'(cq_if.send_cmd), 64'd0);
      send_mrd(8'h23, 16'h3003, 11'd5, 7'h18, 3'd4, 3'd4);
      check_val("t028_count1", 64'(dut.u_fifo.count_q), 64'd1);
      pop_check("t028_d");

      // link drop during ST_DROP with two queued
      send_mrd(8'h30, 16'h4000, 11'd1, 7'h00, 3'd0, 3'd0);
      send_mrd(8'h31, 16'h4001, 11'd1, 7'h00, 3'd0, 3'd0);
      send_beat(mk_desc(4'b0001, 16'h4002, 8'h32, 11'd4, 7'h00, 3'd0, 3'd0), 1'b0);
      check_val("t029_drop", 64'(dut.state_q), 64'(ST_DROP));
      check_val("t029_count2", 64'(dut.u_fifo.count_q), 64'd2);
      user_lnk_up = 1'b0;
      @(negedge user_clk);
      check_cleared("t029_flush");
      exp_q.delete();
      user_lnk_up = 1'b1;
      @(negedge user_clk);
      check_val("t029_tready", 64'(cq_if.m_axis_cq_tready), 64'h3F_FFFF);
      send_mrd(8'h40, 16'h1234, 11'd5, 7'h2C, 3'd6, 3'd1);
      check_val("t029_rd_cnt", 64'(rd_req_cnt), 64'd1);
      pop_check("t029");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_cq.md
RX_CQ -- requirements
Module: rx_cq

Interface
REQ-001 Parameters (name, default, meaning); clock/reset: one clock; reset is asynchronous and active-low.
- C_DATA_WIDTH, 128, CQ data width (only 128 supported).
- AXI4_CQ_TUSER_WIDTH, 88, CQ tuser width.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- FIFO_DEPTH, 4, read-request queue depth (power of 2).
REQ-002 Ports (name, direction, width, meaning):
- user_clk  in  1  sole clock.
- user_reset_n  in  1  async active-low reset.
- user_lnk_up  in  1  link up; low = treated as reset (synchronous flush).
- m_axis_cq_tdata  in  128  completer-request data.
- m_axis_cq_tuser  in  AXI4_CQ_TUSER_WIDTH  sideband (ignored except parity passthrough none).
- m_axis_cq_tlast  in  1  last beat.
- m_axis_cq_tkeep  in  KEEP_WIDTH  dword enables.
- m_axis_cq_tvalid  in  1  beat valid.
- m_axis_cq_tready  out  22  ready; all bits identical.
- send_cmd  out  1  queue non-empty; head request presented.
- send_cmd_done  in  1  one-cycle pulse; pops head.
- req_requester_id  out  16  head requester ID.
- req_tag  out  8  head tag.
- req_addr  out  7  head address[6:0].
- req_dw_cnt  out  11  head dword count.
- req_byte_cnt  out  13  head byte count.
- req_tc  out  3; req_attr  out  3  head TC/attributes.
- rd_req_cnt, wr_req_cnt, bad_req_cnt  out  16 each  statistics.

Function
REQ-003 Beat transfers only when tvalid and tready[0] both high.
REQ-004 FSM states: ST_IDLE (expect descriptor), ST_DROP (discard payload until tlast).
REQ-005 ST_IDLE: tready = not full; ST_DROP: tready = 1.
REQ-006 Descriptor fields: addr = tdata[6:2]&2'b00 padded to 7 bits (addr[1:0]=0); dw_cnt = tdata[74:64]; type = tdata[78:75]; requester_id = tdata[95:80]; tag = tdata[103:96]; tc = tdata[123:121]; attr = tdata[126:124].
REQ-007 Type 0000 (MemRd): push one entry, rd_req_cnt+1; stay ST_IDLE if tlast else go ST_DROP.
REQ-008 Type 0001 (MemWr): no push, wr_req_cnt+1; go ST_DROP if tlast=0.
REQ-009 Any other type: no push, bad_req_cnt+1; go ST_DROP if tlast=0.
REQ-010 ST_DROP: on accepted beat with tlast=1 return to ST_IDLE; payload discarded.
REQ-011 req_byte_cnt = dw_cnt*4, except dw_cnt=0 gives 4096 (13'h1000).
REQ-012 Latency: descriptor accepted cycle N -> send_cmd and head fields valid cycle N+1.
REQ-013 Head fields stable while send_cmd high and no pop.
REQ-014 send_cmd_done while empty: ignored, no pointer change.
REQ-015 Push and pop same cycle: occupancy unchanged, order preserved.
REQ-016 Full: tready low in ST_IDLE; no entry ever lost or overwritten.
REQ-017 Counters wrap 16'hFFFF -> 0.
REQ-018 Order: FIFO strictly first-in first-out.

Reset
REQ-019 user_reset_n low: FSM ST_IDLE, queue empty, send_cmd=0, tready=0, all counters 0, head fields 0.
REQ-020 user_lnk_up low: same state as REQ-019 on next edge, including mid-packet in ST_DROP.
REQ-021 Reset deassertion: tready rises no earlier than first edge after release.

Structure
REQ-022 Shared package nvme_pcie_pkg: CQ request-type codes, FSM state encodings, BAR0 constant, descriptor bit-position constants.
REQ-023 One sub-module cq_req_fifo (parameterised depth/width, full/empty flags, registered output).

Verification
REQ-024 MemRd, tag 8'h05, req ID 16'h0100, dw_cnt 16, addr 0x40, tlast=1 -> next cycle send_cmd=1, req_byte_cnt=64, req_tag=5, rd_req_cnt=1.
REQ-025 Five MemRd, no send_cmd_done -> fifth held off: tready=0 after fourth; after one pop, fifth accepted; tags emerge in order.
REQ-026 MemWr dw_cnt 1, two beats -> no push, wr_req_cnt=1, FSM returns ST_IDLE after tlast.
REQ-027 MemRd dw_cnt 0 -> req_byte_cnt=4096.
REQ-028 Push with simultaneous pop at occupancy 2 -> occupancy stays 2; send_cmd_done while empty -> no effect.
REQ-029 user_lnk_up dropped during ST_DROP with 2 queued -> queue empty, counters 0, ST_IDLE, next descriptor parsed correctly.
